instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 167 ++++++++++++++++
 tb/tb_instruction_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Assembles a big-endian byte stream into 32-bit instruction
//               words and writes them to instruction memory while holding the
//               CPU. Optional trailing XOR checksum byte when the macro
//               LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  word_count,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      CHECK = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3
   } state_t;
`endif

   state_t      state;
   logic [7:0]  words_left;
   logic [1:0]  byte_cnt;
   logic        byte_take;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  xsum;
   logic        err_q;

   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   assign byte_take = byte_valid && byte_ready;
   assign cpu_hold  = busy;

   // Outputs are registered and updated together with the state they belong to.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'h0000_0000;
         byte_cnt   <= 2'd0;
         words_left <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
         xsum       <= 8'h00;
         err_q      <= 1'b0;
`endif
      end else begin
         imem_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  words_left <= word_count;
                  byte_cnt   <= 2'd0;
                  imem_addr  <= BASE_ADDR;
                  busy       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  xsum       <= 8'h00;
                  err_q      <= 1'b0;
`endif
                  if (word_count != 8'd0) begin
                     state      <= RECV;
                     byte_ready <= 1'b1;
                  end else begin
`ifdef LOADER_CHECKSUM_EN
                     state      <= CHECK;
                     byte_ready <= 1'b1;
`else
                     state      <= DONE;
                     done       <= 1'b1;
`endif
                  end
               end
            end

            RECV: begin
               if (byte_take) begin
                  imem_wdata <= {imem_wdata[23:0], byte_data};
                  byte_cnt   <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  xsum       <= xsum ^ byte_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     state      <= WRITE;
                     byte_ready <= 1'b0;
                     imem_we    <= 1'b1;
                  end
               end
            end

            WRITE: begin
               // Address wraps naturally modulo 2^32.
               imem_addr  <= imem_addr + 32'd4;
               words_left <= words_left - 8'd1;
               if (words_left > 8'd1) begin
                  state      <= RECV;
                  byte_ready <= 1'b1;
               end else begin
`ifdef LOADER_CHECKSUM_EN
                  state      <= CHECK;
                  byte_ready <= 1'b1;
`else
                  state      <= DONE;
                  done       <= 1'b1;
`endif
               end
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (byte_take) begin
                  err_q      <= (byte_data != xsum);
                  state      <= DONE;
                  byte_ready <= 1'b0;
                  done       <= 1'b1;
               end
            end
`endif

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state      <= IDLE;
               byte_ready <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Table-driven bench for instruction_loader (two base addresses).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  word_count;
   logic        byte_valid;
   logic [7:0]  byte_data;

   logic        byte_ready0, imem_we0, cpu_hold0, busy0, done0, error0;
   logic [31:0] imem_addr0, imem_wdata0;
   logic        byte_ready1, imem_we1, cpu_hold1, busy1, done1, error1;
   logic [31:0] imem_addr1, imem_wdata1;

   instruction_loader #(.BASE_ADDR(32'h0000_0000)) dut0 (
      .clock(clock), .reset(reset), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready0),
      .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_wdata(imem_wdata0),
      .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0)
   );

   instruction_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut1 (
      .clock(clock), .reset(reset), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready1),
      .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
      .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0]  wc;
      logic [63:0] bytes;
      logic        toggle;
      logic        restart;
      logic        bad_sum;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   vec_t        vecs [6];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] wa0 [$];
   logic [31:0] wd0 [$];
   logic [31:0] wa1 [$];
   logic [31:0] wd1 [$];
   int          done_cnt = 0;
   int          hold_bad = 0;
   int          hold_low = 0;
   bit          sess_active = 1'b0;

   always @(negedge clock) begin
      if (!reset) begin
         if (imem_we0) begin wa0.push_back(imem_addr0); wd0.push_back(imem_wdata0); end
         if (imem_we1) begin wa1.push_back(imem_addr1); wd1.push_back(imem_wdata1); end
         if (done0) done_cnt++;
         if (cpu_hold0 !== busy0 || cpu_hold1 !== busy1) hold_bad++;
         if (sess_active && cpu_hold0 !== 1'b1) hold_low++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got = 1'b0;
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!got && n < 20) begin
         @(negedge clock);
         got = (byte_ready0 === 1'b1);
         @(posedge clock); #1;
         n++;
      end
      byte_valid = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL byte_handshake: byte %h never accepted, byte_ready 0 expected 1", b);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          s0 = wa0.size();
      int          s1 = wa1.size();
      int          d0 = done_cnt;
      int          h0 = hold_low;
      int          n = 0;
      bit          seen = 1'b0;
      logic [7:0]  b;
      logic [7:0]  xs = 8'h00;
      logic [31:0] exp_w;
      logic        exp_err;
      @(posedge clock); #1;
      start = 1'b1; word_count = v.wc;
      @(posedge clock); #1;
      start = 1'b0; sess_active = 1'b1;
      for (int i = 0; i < 4 * int'(v.wc); i++) begin
         b  = v.bytes[63 - 8*i -: 8];
         xs = xs ^ b;
         if (v.toggle) begin @(posedge clock); #1; end
         if (v.restart && i == 1) begin start = 1'b1; word_count = 8'd5; end
         send_byte(b);
         start = 1'b0;
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(xs ^ {7'd0, v.bad_sum});
      exp_err = v.bad_sum;
`else
      exp_err = 1'b0;
`endif
      while (!seen && n < 12) begin
         @(negedge clock);
         n++;
         seen = (done0 === 1'b1);
      end
      sess_active = 1'b0;
      chk($sformatf("v%0d_done_seen", idx), {31'd0, seen}, 32'd1);
`ifndef LOADER_CHECKSUM_EN
      if (v.wc == 8'd0) chk($sformatf("v%0d_zero_latency_le2", idx), {31'd0, n <= 2}, 32'd1);
`endif
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk($sformatf("v%0d_nwrites0", idx), wa0.size() - s0, {24'd0, v.wc});
      chk($sformatf("v%0d_nwrites1", idx), wa1.size() - s1, {24'd0, v.wc});
      for (int w = 0; w < int'(v.wc) && w < 2; w++) begin
         exp_w = (w == 0) ? v.w0 : v.w1;
         if (wa0.size() > s0 + w) begin
            chk($sformatf("v%0d_addr0_w%0d", idx, w), wa0[s0 + w], 32'h0000_0000 + 32'(4 * w));
            chk($sformatf("v%0d_data0_w%0d", idx, w), wd0[s0 + w], exp_w);
         end
         if (wa1.size() > s1 + w) begin
            chk($sformatf("v%0d_addr1_w%0d", idx, w), wa1[s1 + w], 32'hFFFF_FFFC + 32'(4 * w));
            chk($sformatf("v%0d_data1_w%0d", idx, w), wd1[s1 + w], exp_w);
         end
      end
      chk($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 32'd1);
      chk($sformatf("v%0d_busy_after", idx), {31'd0, busy0}, 32'd0);
      chk($sformatf("v%0d_error", idx), {31'd0, error0}, {31'd0, exp_err});
      chk($sformatf("v%0d_hold_during", idx), hold_low - h0, 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_byte_ready"}, {31'd0, byte_ready0}, 32'd0);
      chk({tag, "_imem_we"},    {31'd0, imem_we0},    32'd0);
      chk({tag, "_cpu_hold"},   {31'd0, cpu_hold0},   32'd0);
      chk({tag, "_busy"},       {31'd0, busy0},       32'd0);
      chk({tag, "_done"},       {31'd0, done0},       32'd0);
      chk({tag, "_error"},      {31'd0, error0},      32'd0);
      chk({tag, "_addr0"},      imem_addr0,           32'h0000_0000);
      chk({tag, "_addr1"},      imem_addr1,           32'hFFFF_FFFC);
      chk({tag, "_wdata"},      imem_wdata0,          32'h0000_0000);
   endtask

   initial begin
      int ws;
      //            wc     bytes                    tog   rst   bad   w0            w1
      vecs[0] = '{8'd2, 64'h8B1F03E0_CB000001, 1'b0, 1'b0, 1'b0, 32'h8B1F03E0, 32'hCB000001};
      vecs[1] = '{8'd2, 64'h8B1F03E0_CB000001, 1'b1, 1'b0, 1'b0, 32'h8B1F03E0, 32'hCB000001};
      vecs[2] = '{8'd1, 64'h01020304_00000000, 1'b0, 1'b0, 1'b0, 32'h01020304, 32'h0};
      vecs[3] = '{8'd1, 64'h01020304_00000000, 1'b0, 1'b0, 1'b1, 32'h01020304, 32'h0};
      vecs[4] = '{8'd0, 64'h0,                 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
      vecs[5] = '{8'd2, 64'hDEADBEEF_00FF00FF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00FF00FF};

      reset = 1'b1; start = 1'b0; word_count = 8'd0; byte_valid = 1'b0; byte_data = 8'd0;
      repeat (2) @(negedge clock);
      chk_reset_vals("por");
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Reset in the middle of word 0: partial word discarded, nothing written.
      ws = wa0.size();
      @(posedge clock); #1;
      start = 1'b1; word_count = 8'd2;
      @(posedge clock); #1;
      start = 1'b0;
      send_byte(8'h8B);
      send_byte(8'h1F);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("midrst_no_write", wa0.size() - ws, 32'd0);
      run_vec(6, vecs[0]);

      chk("hold_equals_busy", hold_bad, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
